id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage CPU. Sits directly upstream of the ALU.
- Latches decoded operands and control from ID.
- Resolves EX/MEM and MEM/WB forwarding, then drives the ALU operands (data1/data2) and ALUCtrl.
- Detects load-use hazards and inserts bubbles itself; honours pipeline stall and flush.

---
 rtl/id_ex_stage_if.sv | 59 +++++
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: ID fields, forwarding sources and EX-side outputs
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          valid_i;
  logic [DW-1:0] RSdata_i;
  logic [DW-1:0] RTdata_i;
  logic [DW-1:0] imm_i;
  logic [AW-1:0] RSaddr_i;
  logic [AW-1:0] RTaddr_i;
  logic [AW-1:0] RDaddr_i;
  logic          uses_rt_i;
  logic          ALUSrc_i;
  logic [2:0]    ALUCtrl_i;
  logic          RegWrite_i;
  logic          MemRead_i;
  logic          MemWrite_i;
  logic          MemtoReg_i;
  logic          stall_i;
  logic          flush_i;
  logic          EXMEM_RegWrite_i;
  logic [AW-1:0] EXMEM_RDaddr_i;
  logic [DW-1:0] EXMEM_data_i;
  logic          MEMWB_RegWrite_i;
  logic [AW-1:0] MEMWB_RDaddr_i;
  logic [DW-1:0] MEMWB_data_i;

  logic [DW-1:0] data1_o;
  logic [DW-1:0] data2_o;
  logic [2:0]    ALUCtrl_o;
  logic [DW-1:0] store_data_o;
  logic [AW-1:0] RDaddr_o;
  logic          RegWrite_o;
  logic          MemRead_o;
  logic          MemWrite_o;
  logic          MemtoReg_o;
  logic          valid_o;
  logic          load_use_o;
  logic [15:0]   bubble_cnt_o;

  modport master (
    output valid_i, RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i,
           uses_rt_i, ALUSrc_i, ALUCtrl_i, RegWrite_i, MemRead_i, MemWrite_i,
           MemtoReg_i, stall_i, flush_i, EXMEM_RegWrite_i, EXMEM_RDaddr_i,
           EXMEM_data_i, MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i,
    input  data1_o, data2_o, ALUCtrl_o, store_data_o, RDaddr_o, RegWrite_o,
           MemRead_o, MemWrite_o, MemtoReg_o, valid_o, load_use_o, bubble_cnt_o
  );

  modport slave (
    input  valid_i, RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i,
           uses_rt_i, ALUSrc_i, ALUCtrl_i, RegWrite_i, MemRead_i, MemWrite_i,
           MemtoReg_i, stall_i, flush_i, EXMEM_RegWrite_i, EXMEM_RDaddr_i,
           EXMEM_data_i, MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i,
    output data1_o, data2_o, ALUCtrl_o, store_data_o, RDaddr_o, RegWrite_o,
           MemRead_o, MemWrite_o, MemtoReg_o, valid_o, load_use_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use bubbles
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic          clk_i,
  input logic          rst_n_i,
  id_ex_stage_if.slave bus
);

  logic          valid_q,      valid_d;
  logic [DW-1:0] rs_data_q,    rs_data_d;
  logic [DW-1:0] rt_data_q,    rt_data_d;
  logic [DW-1:0] imm_q,        imm_d;
  logic [AW-1:0] rs_addr_q,    rs_addr_d;
  logic [AW-1:0] rt_addr_q,    rt_addr_d;
  logic [AW-1:0] rd_addr_q,    rd_addr_d;
  logic          alu_src_q,    alu_src_d;
  logic [2:0]    alu_ctrl_q,   alu_ctrl_d;
  logic          reg_write_q,  reg_write_d;
  logic          mem_read_q,   mem_read_d;
  logic          mem_write_q,  mem_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;

  logic          ex_hit_a, wb_hit_a, ex_hit_b, wb_hit_b;
  logic [DW-1:0] fwd_a, fwd_b;
  logic          load_use;
  logic          load_bubble;

  always_comb begin
    ex_hit_a = bus.EXMEM_RegWrite_i && (bus.EXMEM_RDaddr_i != '0) && (bus.EXMEM_RDaddr_i == rs_addr_q);
    wb_hit_a = bus.MEMWB_RegWrite_i && (bus.MEMWB_RDaddr_i != '0) && (bus.MEMWB_RDaddr_i == rs_addr_q);
    ex_hit_b = bus.EXMEM_RegWrite_i && (bus.EXMEM_RDaddr_i != '0) && (bus.EXMEM_RDaddr_i == rt_addr_q);
    wb_hit_b = bus.MEMWB_RegWrite_i && (bus.MEMWB_RDaddr_i != '0) && (bus.MEMWB_RDaddr_i == rt_addr_q);
    // The younger producer (EX/MEM) holds the newest value, so it wins over MEM/WB.
    fwd_a = ex_hit_a ? bus.EXMEM_data_i : (wb_hit_a ? bus.MEMWB_data_i : rs_data_q);
    fwd_b = ex_hit_b ? bus.EXMEM_data_i : (wb_hit_b ? bus.MEMWB_data_i : rt_data_q);
  end

  assign load_use = valid_q && mem_read_q && (rd_addr_q != '0) && bus.valid_i &&
                    ((rd_addr_q == bus.RSaddr_i) ||
                     (bus.uses_rt_i && (rd_addr_q == bus.RTaddr_i)));

  assign load_bubble = bus.flush_i || (!bus.stall_i && load_use);

  always_comb begin
    valid_d      = valid_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_addr_d    = rs_addr_q;
    rt_addr_d    = rt_addr_q;
    rd_addr_d    = rd_addr_q;
    alu_src_d    = alu_src_q;
    alu_ctrl_d   = alu_ctrl_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (load_bubble) begin
      valid_d      = 1'b0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      rs_addr_d    = '0;
      rt_addr_d    = '0;
      rd_addr_d    = '0;
      alu_src_d    = 1'b0;
      alu_ctrl_d   = 3'b000;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (bus.stall_i) begin
      // Capture forwarded operands so they survive the producer retiring mid-stall.
      rs_data_d = fwd_a;
      rt_data_d = fwd_b;
    end else begin
      valid_d      = bus.valid_i;
      rs_data_d    = bus.RSdata_i;
      rt_data_d    = bus.RTdata_i;
      imm_d        = bus.imm_i;
      rs_addr_d    = bus.RSaddr_i;
      rt_addr_d    = bus.RTaddr_i;
      rd_addr_d    = bus.RDaddr_i;
      alu_src_d    = bus.ALUSrc_i;
      alu_ctrl_d   = bus.ALUCtrl_i;
      reg_write_d  = bus.RegWrite_i;
      mem_read_d   = bus.MemRead_i;
      mem_write_d  = bus.MemWrite_i;
      mem_to_reg_d = bus.MemtoReg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= 3'b000;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      rd_addr_q    <= rd_addr_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_q <= 16'h0000;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.bubble_cnt_o = bubble_cnt_q;
`else
  assign bus.bubble_cnt_o = 16'h0000;
`endif

  assign bus.data1_o      = fwd_a;
  assign bus.store_data_o = fwd_b;
  assign bus.data2_o      = alu_src_q ? imm_q : fwd_b;
  assign bus.ALUCtrl_o    = alu_ctrl_q;
  assign bus.RDaddr_o     = rd_addr_q;
  assign bus.RegWrite_o   = reg_write_q;
  assign bus.MemRead_o    = mem_read_q;
  assign bus.MemWrite_o   = mem_write_q;
  assign bus.MemtoReg_o   = mem_to_reg_q;
  assign bus.valid_o      = valid_q;
  assign bus.load_use_o   = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  id_ex_stage_if #(.DW(32), .AW(5)) bus ();

  id_ex_stage #(.DW(32), .AW(5)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    bus.valid_i    = 1'b0;
    bus.RSdata_i   = '0;
    bus.RTdata_i   = '0;
    bus.imm_i      = '0;
    bus.RSaddr_i   = '0;
    bus.RTaddr_i   = '0;
    bus.RDaddr_i   = '0;
    bus.uses_rt_i  = 1'b0;
    bus.ALUSrc_i   = 1'b0;
    bus.ALUCtrl_i  = 3'b000;
    bus.RegWrite_i = 1'b0;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.MemtoReg_i = 1'b0;
  endtask

  task automatic clear_fwd();
    bus.EXMEM_RegWrite_i = 1'b0;
    bus.EXMEM_RDaddr_i   = '0;
    bus.EXMEM_data_i     = '0;
    bus.MEMWB_RegWrite_i = 1'b0;
    bus.MEMWB_RDaddr_i   = '0;
    bus.MEMWB_data_i     = '0;
  endtask

  logic [15:0] cnt_exp;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cnt_exp  = 16'd0;
    rst_n    = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    clear_id();
    clear_fwd();
    #12;
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_aluctrl", {29'd0, bus.ALUCtrl_o}, 32'd0);
    check("rst_data1", bus.data1_o, 32'd0);
    check("rst_cnt", {16'd0, bus.bubble_cnt_o}, 32'd0);
    rst_n = 1'b1;

    // Normal load: r4 = r3 + imm
    @(negedge clk);
    bus.valid_i = 1'b1; bus.RSaddr_i = 5'd3; bus.RSdata_i = 32'h11;
    bus.ALUSrc_i = 1'b1; bus.imm_i = 32'hFFFF_FFF0; bus.ALUCtrl_i = 3'b010;
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd4;
    step();
    clear_id();
    check("ld_valid", {31'd0, bus.valid_o}, 32'd1);
    check("ld_regwrite", {31'd0, bus.RegWrite_o}, 32'd1);
    check("ld_data2_imm", bus.data2_o, 32'hFFFF_FFF0);
    check("ld_data1", bus.data1_o, 32'h11);
    check("ld_aluctrl", {29'd0, bus.ALUCtrl_o}, 32'd2);
    check("ld_rdaddr", {27'd0, bus.RDaddr_o}, 32'd4);

    // Double forward on RS = 3
    bus.EXMEM_RegWrite_i = 1'b1; bus.EXMEM_RDaddr_i = 5'd3; bus.EXMEM_data_i = 32'h1234;
    bus.MEMWB_RegWrite_i = 1'b1; bus.MEMWB_RDaddr_i = 5'd3; bus.MEMWB_data_i = 32'h5678;
    #1;
    check("fwd_both_exmem", bus.data1_o, 32'h1234);
    bus.EXMEM_RegWrite_i = 1'b0;
    #1;
    check("fwd_memwb", bus.data1_o, 32'h5678);
    clear_fwd();

    // Asynchronous reset mid-operation
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("arst_regwrite", {31'd0, bus.RegWrite_o}, 32'd0);
    check("arst_aluctrl", {29'd0, bus.ALUCtrl_o}, 32'd0);
    check("arst_cnt", {16'd0, bus.bubble_cnt_o}, 32'd0);
    rst_n = 1'b1;

    // Register 0 is never forwarded
    @(negedge clk);
    bus.valid_i = 1'b1; bus.RSaddr_i = 5'd0; bus.RSdata_i = 32'd0; bus.RDaddr_i = 5'd2;
    bus.RegWrite_i = 1'b1; bus.ALUCtrl_i = 3'b010;
    step();
    clear_id();
    bus.EXMEM_RegWrite_i = 1'b1; bus.EXMEM_RDaddr_i = 5'd0; bus.EXMEM_data_i = 32'hDEAD;
    #1;
    check("r0_no_fwd", bus.data1_o, 32'd0);
    clear_fwd();

    // Load-use: lw r5 then add r6 = r5 + r1
    @(negedge clk);
    bus.valid_i = 1'b1; bus.RSaddr_i = 5'd2; bus.RSdata_i = 32'h100; bus.ALUSrc_i = 1'b1;
    bus.imm_i = 32'd4; bus.ALUCtrl_i = 3'b010; bus.RegWrite_i = 1'b1; bus.MemRead_i = 1'b1;
    bus.MemtoReg_i = 1'b1; bus.RDaddr_i = 5'd5;
    step();
    clear_id();
    bus.valid_i = 1'b1; bus.RSaddr_i = 5'd5; bus.RTaddr_i = 5'd1; bus.uses_rt_i = 1'b1;
    bus.RSdata_i = 32'h0; bus.RTdata_i = 32'h10; bus.ALUCtrl_i = 3'b010;
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd6;
    #1;
    check("lu_detect", {31'd0, bus.load_use_o}, 32'd1);
    step();
`ifdef ID_EX_PERF_CNT_EN
    cnt_exp = 16'd1;
`endif
    check("lu_bubble_valid", {31'd0, bus.valid_o}, 32'd0);
    check("lu_bubble_regwrite", {31'd0, bus.RegWrite_o}, 32'd0);
    check("lu_drop", {31'd0, bus.load_use_o}, 32'd0);
    check("lu_cnt", {16'd0, bus.bubble_cnt_o}, {16'd0, cnt_exp});
    step();
    clear_id();
    bus.MEMWB_RegWrite_i = 1'b1; bus.MEMWB_RDaddr_i = 5'd5; bus.MEMWB_data_i = 32'h77;
    #1;
    check("lu_add_valid", {31'd0, bus.valid_o}, 32'd1);
    check("lu_add_data1", bus.data1_o, 32'h77);
    check("lu_add_data2", bus.data2_o, 32'h10);
    check("lu_add_rd", {27'd0, bus.RDaddr_o}, 32'd6);
    clear_fwd();

    // Stall with a forwarded RT value
    @(negedge clk);
    bus.valid_i = 1'b1; bus.RTaddr_i = 5'd7; bus.uses_rt_i = 1'b1; bus.RTdata_i = 32'h0;
    bus.ALUSrc_i = 1'b1; bus.imm_i = 32'd8; bus.MemWrite_i = 1'b1; bus.ALUCtrl_i = 3'b010;
    step();
    clear_id();
    bus.MEMWB_RegWrite_i = 1'b1; bus.MEMWB_RDaddr_i = 5'd7; bus.MEMWB_data_i = 32'hAA55;
    bus.stall_i = 1'b1;
    #1;
    check("st_fwd0", bus.store_data_o, 32'hAA55);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.MEMWB_RDaddr_i = 5'd9; bus.MEMWB_data_i = 32'h1111;
      #1;
      check($sformatf("st_hold%0d", i), bus.store_data_o, 32'hAA55);
    end
    check("st_valid", {31'd0, bus.valid_o}, 32'd1);
    check("st_cnt", {16'd0, bus.bubble_cnt_o}, {16'd0, cnt_exp});
    clear_fwd();

    // Flush beats stall
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1; bus.RegWrite_i = 1'b1; bus.MemRead_i = 1'b1; bus.RDaddr_i = 5'd3;
    step();
`ifdef ID_EX_PERF_CNT_EN
    cnt_exp = 16'd2;
`endif
    bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    clear_id();
    #1;
    check("fl_valid", {31'd0, bus.valid_o}, 32'd0);
    check("fl_ctrl", {28'd0, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.MemtoReg_o}, 32'd0);
    check("fl_cnt", {16'd0, bus.bubble_cnt_o}, {16'd0, cnt_exp});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
